// File: rtl/mult32_seq.sv
// Sequential 32x32 unsigned shift-and-add multiplier built on one shared 32-bit
// ripple-carry adder; retires one multiplier bit per cycle, valid/ready on both sides.

module fa32 (
    input  logic [31:0] i_x,
    input  logic [31:0] i_y,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);
    logic [32:0] w_c;

    assign w_c[0] = i_cin;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_bit
            assign o_sum[gi]  = i_x[gi] ^ i_y[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (i_x[gi] & i_y[gi]) | (w_c[gi] & (i_x[gi] ^ i_y[gi]));
        end
    endgenerate

    assign o_cout = w_c[32];
endmodule

module mult32_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] product,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_mcand;
    logic [63:0] r_acc;
    logic [5:0]  r_cnt;
    logic [63:0] r_product;

    logic [31:0] w_addend;
    logic [31:0] w_sum;
    logic        w_cout;
    logic [63:0] w_acc_step;
    logic        w_accept;
    logic        w_last;

    // Operand mux feeds the single shared adder; inputs are always reset registers.
    assign w_addend   = r_acc[0] ? r_mcand : 32'd0;
    assign w_acc_step = {w_cout, w_sum, r_acc[31:1]};
    assign w_accept   = (r_state == IDLE) && in_valid && !flush;
    assign w_last     = (r_cnt == 6'd31);

    fa32 u_fa32 (
        .i_x    (r_acc[63:32]),
        .i_y    (w_addend),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_next = RUN;
            end
            RUN: begin
                if (flush)       w_state_next = IDLE;
                else if (w_last) w_state_next = DONE;
            end
            DONE: begin
                if (flush || out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand   <= 32'd0;
            r_acc     <= 64'd0;
            r_cnt     <= 6'd0;
            r_product <= 64'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mcand <= a;
                        r_acc   <= {32'd0, b};
                        r_cnt   <= 6'd0;
                    end
                end
                RUN: begin
                    // A flushed step is discarded; product keeps its previous value.
                    if (!flush) begin
                        r_acc <= w_acc_step;
                        r_cnt <= r_cnt + 6'd1;
                        if (w_last) r_product <= w_acc_step;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign product   = r_product;
endmodule

// File: tb/tb_mult32_seq.sv
// Directed self-checking bench for mult32_seq: latency, product values,
// backpressure, flush, and asynchronous reset mid-operation.

module tb_mult32_seq;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        busy;

    int n_checks;
    int n_errors;

    mult32_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%016h", tag, got);
        end
    endtask

    // Accept one operand pair, then count edges after the accept edge until
    // out_valid is seen (bounded). Optionally pulse in_valid with junk mid-RUN.
    task automatic do_op(input logic [31:0] a_v, input logic [31:0] b_v,
                         input bit pulse, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        a = a_v;
        b = b_v;
        check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
            in_valid = pulse && (lat == 5);
            a = 32'hAAAA_AAAA;
            b = 32'h5555_5555;
        end
        in_valid = 1'b0;
    endtask

    int lat;
    int seen_valid;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 32'd0;
        b         = 32'd0;
        flush     = 1'b0;
        out_ready = 1'b1;

        #3;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 3 * 5
        do_op(32'd3, 32'd5, 1'b0, lat);
        check("lat_3x5", 64'(lat), 64'd32);
        check("prod_3x5", product, 64'h0000_0000_0000_000F);
        check("busy_in_done", {63'd0, busy}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("busy_after_hs", {63'd0, busy}, 64'd0);

        // Carry retention into the top bit
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
        check("lat_max", 64'(lat), 64'd32);
        check("prod_max", product, 64'hFFFF_FFFE_0000_0001);

        do_op(32'd0, 32'hDEAD_BEEF, 1'b0, lat);
        check("lat_a0", 64'(lat), 64'd32);
        check("prod_a0", product, 64'd0);

        do_op(32'h1234_5678, 32'd0, 1'b0, lat);
        check("lat_b0", 64'(lat), 64'd32);
        check("prod_b0", product, 64'd0);

        // Backpressure with ignored in_valid pulses during RUN and DONE
        @(negedge clk);
        out_ready = 1'b0;
        do_op(32'h0001_0000, 32'h0001_0000, 1'b1, lat);
        check("lat_bp", 64'(lat), 64'd32);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 3);
            a = 32'd1;
            b = 32'd1;
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_product", product, 64'h0000_0001_0000_0000);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_released_idle", {63'd0, busy}, 64'd0);

        // flush while IDLE blocks acceptance
        in_valid = 1'b1;
        flush    = 1'b1;
        a = 32'd9;
        b = 32'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        check("flush_idle_no_accept", {63'd0, busy}, 64'd0);

        // flush in the 10th RUN cycle
        in_valid = 1'b1;
        a = 32'd9;
        b = 32'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        check("busy_before_flush", {63'd0, busy}, 64'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_product_kept", product, 64'h0000_0001_0000_0000);
        seen_valid = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        check("flush_no_out_valid", 64'(seen_valid), 64'd0);

        do_op(32'd7, 32'd6, 1'b0, lat);
        check("lat_7x6", 64'(lat), 64'd32);
        check("prod_7x6", product, 64'd42);

        // Asynchronous reset mid-clock in RUN cycle 20
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'd5;
        b = 32'd5;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_in_ready", {63'd0, in_ready}, 64'd1);
        check("arst_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(32'h8000_0000, 32'd2, 1'b0, lat);
        check("lat_after_rst", 64'(lat), 64'd32);
        check("prod_after_rst", product, 64'h0000_0001_0000_0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
